// File: rtl/hog_bus_pkg.sv
// Shared definitions for the hog bus arbiter/dispatch pair: FSM encodings,
// default geometry and the valid/ready beat convention.
package hog_bus_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    localparam int DEF_BUS_WIDTH = 128;
    localparam int DEF_LEVELS    = 7;
    localparam int DEF_BURST_LEN = 8;

    // A beat transfers only on the cycle where both sides agree.
    function automatic logic beat_fire(input logic valid, input logic ready);
        return valid && ready;
    endfunction

endpackage

// File: rtl/bus_dispatch_if.sv
// Upstream beat stream plus fanned-out per-level stream of the dispatcher.
// master = bridge/deserializer side, slave = dispatcher side.
interface bus_dispatch_if
    import hog_bus_pkg::*;
#(
    parameter int BUS_WIDTH = DEF_BUS_WIDTH,
    parameter int LEVELS    = DEF_LEVELS
);
    localparam int DEST_WIDTH = $clog2(LEVELS);

    logic                  in_valid;
    logic                  in_ready;
    logic [BUS_WIDTH-1:0]  in_stream;
    logic [DEST_WIDTH-1:0] in_dest;
    logic                  in_last;
    logic [LEVELS-1:0]     out_valid;
    logic [LEVELS-1:0]     out_ready;
    logic [BUS_WIDTH-1:0]  out_stream;
    logic                  out_last;

    modport master (
        output in_valid, in_stream, in_dest, in_last, out_ready,
        input  in_ready, out_valid, out_stream, out_last
    );

    modport slave (
        input  in_valid, in_stream, in_dest, in_last, out_ready,
        output in_ready, out_valid, out_stream, out_last
    );

endinterface

// File: rtl/bus_pipe_reg.sv
// One-entry valid/ready register slice; accepts a new word in the same cycle
// the held word drains, so it sustains one word per cycle.
module bus_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    assign o_ready = !r_full || i_ready;
    assign o_valid = r_full;
    assign o_data  = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_valid && o_ready) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_ready) begin
            r_full <= 1'b0;
        end
    end

endmodule

// File: rtl/bus_dispatch.sv
// Routes read-data bursts from the bus bridge to one of LEVELS deserializers,
// steering each burst by the destination seen on its first beat.
module bus_dispatch
    import hog_bus_pkg::*;
#(
    parameter int BUS_WIDTH = DEF_BUS_WIDTH,
    parameter int LEVELS    = DEF_LEVELS,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic           clk,
    input  logic           rst,
    bus_dispatch_if.slave  bus,
    output logic           drop_err
);

    localparam int DEST_WIDTH = $clog2(LEVELS);
    localparam int CNT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int PAY_W      = BUS_WIDTH + DEST_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);

    state_t                r_state;
    logic [CNT_W-1:0]      r_beat_cnt;
    logic [DEST_WIDTH-1:0] r_cur_dest;
    logic                  r_drop_err;

    logic                  w_accept;
    logic                  w_dest_ok;
    logic                  w_end;
    logic                  w_fwd;
    logic                  w_slice_ready;
    logic                  w_full;
    logic                  w_sel_ready;
    logic [DEST_WIDTH-1:0] w_fwd_dest;
    logic [PAY_W-1:0]      w_pay_in;
    logic [PAY_W-1:0]      w_pay_out;
    logic [LEVELS-1:0]     w_sel_onehot;
    logic [BUS_WIDTH-1:0]  w_q_data;
    logic [DEST_WIDTH-1:0] w_q_dest;
    logic                  w_q_last;

    // Extra bit keeps the range check correct when LEVELS is a power of two.
    assign w_dest_ok  = {1'b0, bus.in_dest} < (DEST_WIDTH + 1)'(LEVELS);
    assign w_end      = bus.in_last || (r_beat_cnt == CNT_MAX);
    assign w_accept   = beat_fire(bus.in_valid, bus.in_ready);
    assign w_fwd      = w_accept && (((r_state == S_IDLE) && w_dest_ok) || (r_state == S_BURST));
    assign w_fwd_dest = (r_state == S_IDLE) ? bus.in_dest : r_cur_dest;
    assign w_pay_in   = {bus.in_stream, w_fwd_dest, w_end};

    assign {w_q_data, w_q_dest, w_q_last} = w_pay_out;

    // Only the held beat's own level can drain the slice.
    assign w_sel_onehot = LEVELS'(1) << w_q_dest;
    assign w_sel_ready  = |(bus.out_ready & w_sel_onehot);

    assign bus.in_ready   = (r_state == S_DROP) ? 1'b1 : w_slice_ready;
    assign bus.out_valid  = w_full ? w_sel_onehot : '0;
    assign bus.out_stream = w_full ? w_q_data : '0;
    assign bus.out_last   = w_full & w_q_last;
    assign drop_err       = r_drop_err;

    bus_pipe_reg #(
        .WIDTH (PAY_W)
    ) u_slice (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_fwd),
        .o_ready (w_slice_ready),
        .i_data  (w_pay_in),
        .o_valid (w_full),
        .i_ready (w_sel_ready),
        .o_data  (w_pay_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_beat_cnt <= '0;
            r_cur_dest <= '0;
            r_drop_err <= 1'b0;
        end else if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    r_cur_dest <= bus.in_dest;
                    if (!w_dest_ok) begin
                        r_drop_err <= 1'b1;
                    end
                    if (w_end) begin
                        r_beat_cnt <= '0;
                    end else begin
                        r_beat_cnt <= CNT_W'(1);
                        r_state    <= w_dest_ok ? S_BURST : S_DROP;
                    end
                end
                S_BURST, S_DROP: begin
                    if (w_end) begin
                        r_beat_cnt <= '0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_beat_cnt <= '0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_dispatch.sv
// Directed and randomized bench for bus_dispatch; every cycle the DUT outputs
// are compared with a queue-based model of the burst routing rules.
module tb_bus_dispatch;

    localparam int BW = 128;
    localparam int LV = 7;
    localparam int BL = 8;

    typedef struct {
        logic [BW-1:0] data;
        logic [2:0]    dest;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic drop_err;

    bus_dispatch_if #(.BUS_WIDTH(BW), .LEVELS(LV)) bif ();

    bus_dispatch #(.BUS_WIDTH(BW), .LEVELS(LV), .BURST_LEN(BL)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bif.slave),
        .drop_err (drop_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: transaction view of bursts, not of the FSM.
    beat_t q[$];
    bit    m_first     = 1'b1;
    bit    m_dest_ok   = 1'b0;
    bit    m_dropping  = 1'b0;
    bit    m_drop_err  = 1'b0;
    int    m_beats     = 0;
    logic [2:0] m_dest = '0;
    bit    last_acc    = 1'b0;

    int rmode = 0;
    int stall_left = 0;
    int stall_lvl = 0;
    int run = 0;
    int max_run = 0;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ready();
        case (rmode)
            0: bif.out_ready = '1;
            1: bif.out_ready = 7'($urandom);
            default: begin
                bif.out_ready = 7'($urandom) | 7'b1111011;
                if (stall_left > 0) begin
                    bif.out_ready[stall_lvl] = 1'b0;
                    stall_left--;
                end else begin
                    bif.out_ready[stall_lvl] = 1'b1;
                end
                bif.out_ready[0] = $urandom_range(0, 1) != 0;
            end
        endcase
    endtask

    task automatic step();
        logic          exp_ir;
        logic [LV-1:0] exp_ov;
        logic [BW-1:0] exp_os;
        logic          exp_ol;
        bit            acc;
        bit            ofire;
        bit            is_end;
        beat_t         b;
        #1;
        exp_ov = '0;
        exp_os = '0;
        exp_ol = 1'b0;
        ofire  = 1'b0;
        if (q.size() > 0) begin
            exp_ov = LV'(1) << q[0].dest;
            exp_os = q[0].data;
            exp_ol = q[0].last;
            ofire  = bif.out_ready[q[0].dest];
        end
        exp_ir = m_dropping || (q.size() == 0) || ofire;
        if (!rst) begin
            chk("out_valid",  BW'(bif.out_valid), BW'(exp_ov));
            chk("out_stream", bif.out_stream, exp_os);
            chk("out_last",   BW'(bif.out_last), BW'(exp_ol));
            chk("in_ready",   BW'(bif.in_ready), BW'(exp_ir));
            chk("drop_err",   BW'(drop_err), BW'(m_drop_err));
        end
        if (bif.out_valid != '0) begin
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        acc = bif.in_valid && exp_ir && !rst;
        if (rst) begin
            q.delete();
            m_first    = 1'b1;
            m_dropping = 1'b0;
            m_drop_err = 1'b0;
            m_beats    = 0;
        end else begin
            if (ofire) void'(q.pop_front());
            if (acc) begin
                if (m_first) begin
                    m_dest    = bif.in_dest;
                    m_dest_ok = int'(bif.in_dest) < LV;
                    m_beats   = 0;
                    if (!m_dest_ok) m_drop_err = 1'b1;
                end
                m_beats++;
                is_end = bif.in_last || (m_beats == BL);
                if (m_dest_ok) begin
                    b.data = bif.in_stream;
                    b.dest = m_dest;
                    b.last = is_end;
                    q.push_back(b);
                end
                m_first    = is_end;
                m_dropping = !is_end && !m_dest_ok;
            end
        end
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [BW-1:0] d, input logic [2:0] dst, input logic lst);
        int guard;
        guard = 0;
        bif.in_valid  = 1'b1;
        bif.in_stream = d;
        bif.in_dest   = dst;
        bif.in_last   = lst;
        do begin
            set_ready();
            step();
            guard++;
        end while (!last_acc && guard < 64);
        if (!last_acc) chk("accept_timeout", BW'(last_acc), BW'(1));
        bif.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bif.in_valid = 1'b0;
        repeat (n) begin
            set_ready();
            step();
        end
    endtask

    initial begin
        bif.in_valid  = 1'b0;
        bif.in_stream = '0;
        bif.in_dest   = '0;
        bif.in_last   = 1'b0;
        bif.out_ready = '1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        chk("reset_in_ready", BW'(bif.in_ready), BW'(1));
        idle(1);

        // Single full burst to level 3.
        rmode = 0;
        for (int i = 1; i <= 8; i++) send_beat(BW'(i), 3'd3, 1'b0);
        idle(3);

        // Early end on beat 3, then a single beat to level 0.
        for (int i = 1; i <= 3; i++) send_beat(BW'(32'h50 + i), 3'd5, i == 3);
        send_beat(BW'(32'hA0), 3'd0, 1'b1);
        idle(3);

        // Backpressure on level 2 mid-burst while level 0 ready toggles.
        for (int i = 1; i <= 4; i++) send_beat(BW'(32'h200 + i), 3'd2, 1'b0);
        rmode = 2;
        stall_lvl = 2;
        stall_left = 4;
        for (int i = 5; i <= 8; i++) send_beat(BW'(32'h200 + i), 3'($urandom_range(0, 7)), 1'b0);
        rmode = 0;
        idle(3);

        // Out-of-range destination, then a normal burst to level 1.
        for (int i = 1; i <= 8; i++) send_beat(BW'(32'h700 + i), 3'd7, 1'b0);
        chk("drop_err_set", BW'(drop_err), BW'(1));
        for (int i = 1; i <= 8; i++) send_beat(BW'(32'h100 + i), 3'd1, 1'b0);
        idle(3);
        chk("drop_err_sticky", BW'(drop_err), BW'(1));

        // Back-to-back bursts: level 6 then level 0 with no gap.
        max_run = 0;
        for (int i = 1; i <= 8; i++) send_beat(BW'(32'h600 + i), 3'd6, 1'b0);
        for (int i = 1; i <= 8; i++) send_beat(BW'(32'h000 + i), 3'd0, 1'b0);
        idle(3);
        chk("b2b_run", BW'(max_run), BW'(16));

        // Reset after beat 4 with the slice holding a beat.
        for (int i = 1; i <= 4; i++) send_beat(BW'(32'h900 + i), 3'd2, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("rst_mid_out_valid", BW'(bif.out_valid), BW'(0));
        chk("rst_mid_drop_err", BW'(drop_err), BW'(0));
        for (int i = 1; i <= 8; i++) send_beat(BW'(32'h400 + i), 3'd4, 1'b0);
        idle(3);

        // Randomized bursts with random readiness and idle gaps.
        rmode = 1;
        for (int k = 0; k < 40; k++) begin
            int len;
            int early;
            logic [2:0] d0;
            len   = $urandom_range(1, 10);
            early = $urandom_range(0, 1);
            d0    = 3'($urandom_range(0, 7));
            for (int i = 1; i <= len; i++) begin
                send_beat({$urandom, $urandom, $urandom, $urandom},
                          (i == 1) ? d0 : 3'($urandom_range(0, 7)),
                          (early != 0) && (i == len));
                if ($urandom_range(0, 5) == 0) idle(1);
            end
        end
        rmode = 0;
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
